sha3_cust5_padder: RTL and testbench

- Message front-end between the l.cust5 ALU path and the Keccak-f[1600] permutation core.
- Accepts message words via head/data/tail/store ops and packs them into a rate-sized block in Keccak byte order.
- Applies SHA3 padding (0x06…0x80) for a runtime-selected mode and supports multi-block messages with a valid/ready block handshake.
- Captures the digest and returns any digest word on a store op.
- Generalises the fixed 32-bit, single-block, SHA3-512-only path to 32/64-bit words, four modes and arbitrary message length.

---
 rtl/sha3_pkg.sv | 38 +++
 rtl/sha3_pad_buffer.sv | 54 +++++
 rtl/sha3_cust5_padder.sv | 265 ++++++++++++++++++++++++++
 tb/tb_sha3_cust5_padder.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha3_pkg.sv
// Shared definitions for the l.cust5 SHA3 message front-end: modes, op codes, pad bytes, FSM states.
package sha3_pkg;

  typedef enum logic [1:0] {
    MODE_224 = 2'd0,
    MODE_256 = 2'd1,
    MODE_384 = 2'd2,
    MODE_512 = 2'd3
  } sha3_mode_e;

  localparam logic [3:0] OP_STORE     = 4'b1000;
  localparam logic [3:0] OP_HEAD      = 4'b0100;
  localparam logic [3:0] OP_DATA      = 4'b0010;
  localparam logic [3:0] OP_TAIL      = 4'b0001;
  localparam logic [3:0] OP_HEAD_TAIL = 4'b0101;

  localparam logic [7:0] PAD_DS  = 8'h06;
  localparam logic [7:0] PAD_END = 8'h80;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ABSORB,
    ST_FLUSH,
    ST_WAIT_DIG,
    ST_DONE
  } state_e;

  // Rate in bytes for each SHA3 output length.
  function automatic logic [7:0] rate_bytes(input logic [1:0] mode);
    case (mode)
      MODE_224: rate_bytes = 8'd144;
      MODE_256: rate_bytes = 8'd136;
      MODE_384: rate_bytes = 8'd104;
      default:  rate_bytes = 8'd72;
    endcase
  endfunction

endpackage

// File: rtl/sha3_pad_buffer.sv
// Byte-addressed block register: clear, (partial) word write at a byte pointer, and pad-byte XOR insert.
// Clear applies before the write and pads within the same cycle.
module sha3_pad_buffer
  import sha3_pkg::*;
#(
  parameter  int unsigned DATA_W        = 32,
  parameter  int unsigned MAX_RATE_BITS = 1152,
  localparam int unsigned NB            = MAX_RATE_BITS / 8,
  localparam int unsigned PTR_W         = $clog2(NB + 1),
  localparam int unsigned WB            = DATA_W / 8,
  localparam int unsigned NB_W          = $clog2(WB) + 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr_i,
  input  logic                     wr_en_i,
  input  logic [PTR_W-1:0]         wr_ptr_i,
  input  logic [DATA_W-1:0]        wr_data_i,
  input  logic [NB_W-1:0]          wr_nbytes_i,
  input  logic                     pad_ds_en_i,
  input  logic [PTR_W-1:0]         pad_ds_pos_i,
  input  logic                     pad_end_en_i,
  input  logic [PTR_W-1:0]         pad_end_pos_i,
  output logic [MAX_RATE_BITS-1:0] buf_o
);

  logic [7:0] buf_q [NB];
  logic [7:0] buf_d [NB];

  always_comb begin
    buf_d = buf_q;
    if (clr_i) buf_d = '{default: 8'h00};
    // First message byte of the word sits in its MSBs.
    if (wr_en_i) begin
      for (int k = 0; k < WB; k++) begin
        if (NB_W'(k) < wr_nbytes_i)
          buf_d[wr_ptr_i + PTR_W'(k)] = wr_data_i[DATA_W-1-8*k -: 8];
      end
    end
    if (pad_ds_en_i)  buf_d[pad_ds_pos_i]  = buf_d[pad_ds_pos_i] ^ PAD_DS;
    if (pad_end_en_i) buf_d[pad_end_pos_i] = buf_d[pad_end_pos_i] ^ PAD_END;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) buf_q <= '{default: 8'h00};
    else     buf_q <= buf_d;
  end

  always_comb begin
    buf_o = '0;
    for (int i = 0; i < NB; i++) buf_o[8*i +: 8] = buf_q[i];
  end

endmodule

// File: rtl/sha3_cust5_padder.sv
// SHA3 message packer/padder between the l.cust5 op stream and the Keccak-f[1600] core.
// Owns the op FSM, block valid/ready handshake and the digest register.
module sha3_cust5_padder
  import sha3_pkg::*;
#(
  parameter int unsigned DATA_W        = 32,
  parameter int unsigned MAX_RATE_BITS = 1152,
  parameter int unsigned OUT_BITS      = 512,
  parameter int unsigned SEL_W         = 6
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       op_valid,
  input  logic [3:0]                 op_code,
  input  logic [DATA_W-1:0]          op_data,
  input  logic [$clog2(DATA_W/8):0]  op_nbytes,
  input  logic [SEL_W-1:0]           op_sel,
  input  logic [1:0]                 mode,
  output logic                       stall,
  output logic                       err,
  output logic                       blk_valid,
  output logic [MAX_RATE_BITS-1:0]   blk_data,
  output logic                       blk_first,
  output logic                       blk_last,
  input  logic                       blk_ready,
  input  logic                       dig_valid,
  input  logic [OUT_BITS-1:0]        dig_data,
  output logic [DATA_W-1:0]          rd_data,
  output logic                       done
);

  localparam int unsigned WB      = DATA_W / 8;
  localparam int unsigned NB_W    = $clog2(WB) + 1;
  localparam int unsigned PTR_W   = $clog2(MAX_RATE_BITS / 8 + 1);
  localparam int unsigned N_WORDS = OUT_BITS / DATA_W;

  state_e               state_q, state_d;
  logic [PTR_W-1:0]     ptr_q, ptr_d;
  logic [1:0]           mode_q, mode_d;
  logic                 first_q, first_d;
  logic                 fin_q, fin_d;
  logic                 extra_q, extra_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic                 stall_q, stall_d;
  logic                 blk_valid_q, blk_valid_d;
  logic                 blk_first_q, blk_first_d;
  logic                 blk_last_q, blk_last_d;
  logic [DATA_W-1:0]    rd_q, rd_d;
  logic [OUT_BITS-1:0]  dig_q, dig_d;

  logic                 buf_clr, buf_wr, pad_ds_en, pad_end_en;
  logic [PTR_W-1:0]     buf_ptr, pad_ds_pos, pad_end_pos;
  logic [NB_W-1:0]      buf_nb;
  logic [PTR_W-1:0]     rate_cur, tail_rate, tail_base, tail_end;
  logic                 nb_bad;
  logic [DATA_W-1:0]    sel_word;

  // A head+tail packs from byte 0 under the mode presented with it.
  assign rate_cur  = PTR_W'(rate_bytes(mode_q));
  assign tail_rate = (op_code == OP_HEAD_TAIL) ? PTR_W'(rate_bytes(mode)) : rate_cur;
  assign tail_base = (op_code == OP_HEAD_TAIL) ? '0 : ptr_q;
  assign tail_end  = tail_base + PTR_W'(op_nbytes);
  assign nb_bad    = op_nbytes > NB_W'(WB);

  // Digest word lookup: lowest-addressed byte lands in the MSBs.
  always_comb begin
    sel_word = '0;
    if (32'(op_sel) < N_WORDS) begin
      for (int k = 0; k < WB; k++)
        sel_word[DATA_W-1-8*k -: 8] = 8'(dig_q >> (32'(op_sel) * DATA_W + 8 * k));
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    mode_d      = mode_q;
    first_d     = first_q;
    fin_d       = fin_q;
    extra_d     = extra_q;
    done_d      = done_q;
    err_d       = 1'b0;
    blk_valid_d = blk_valid_q;
    blk_first_d = blk_first_q;
    blk_last_d  = blk_last_q;
    rd_d        = rd_q;
    dig_d       = dig_q;
    buf_clr     = 1'b0;
    buf_wr      = 1'b0;
    buf_ptr     = ptr_q;
    buf_nb      = op_nbytes;
    pad_ds_en   = 1'b0;
    pad_end_en  = 1'b0;
    pad_ds_pos  = tail_end;
    pad_end_pos = tail_rate - PTR_W'(1);

    case (state_q)
      ST_FLUSH: begin
        if (blk_ready) begin
          blk_valid_d = 1'b0;
          blk_first_d = 1'b0;
          blk_last_d  = 1'b0;
          buf_clr     = 1'b1;
          first_d     = 1'b0;
          ptr_d       = '0;
          state_d     = ST_WAIT_DIG;
        end
      end
      ST_WAIT_DIG: begin
        if (dig_valid) begin
          if (fin_q) begin
            dig_d   = dig_data;
            done_d  = 1'b1;
            fin_d   = 1'b0;
            state_d = ST_DONE;
          end else if (extra_q) begin
            // Message ended exactly on a block boundary: emit a pad-only block.
            extra_d     = 1'b0;
            pad_ds_en   = 1'b1;
            pad_ds_pos  = '0;
            pad_end_en  = 1'b1;
            pad_end_pos = rate_cur - PTR_W'(1);
            blk_valid_d = 1'b1;
            blk_first_d = first_q;
            blk_last_d  = 1'b1;
            fin_d       = 1'b1;
            state_d     = ST_FLUSH;
          end else begin
            state_d = ST_ABSORB;
          end
        end
      end
      default: begin
        if (op_valid) begin
          case (op_code)
            OP_STORE: rd_d = sel_word;
            OP_HEAD: begin
              buf_clr = 1'b1;
              buf_wr  = 1'b1;
              buf_ptr = '0;
              buf_nb  = NB_W'(WB);
              mode_d  = mode;
              first_d = 1'b1;
              done_d  = 1'b0;
              extra_d = 1'b0;
              fin_d   = 1'b0;
              ptr_d   = PTR_W'(WB);
              state_d = ST_ABSORB;
            end
            OP_DATA: begin
              if (state_q == ST_ABSORB) begin
                buf_wr = 1'b1;
                buf_nb = NB_W'(WB);
                ptr_d  = ptr_q + PTR_W'(WB);
                if (ptr_d == rate_cur) begin
                  blk_valid_d = 1'b1;
                  blk_first_d = first_q;
                  blk_last_d  = 1'b0;
                  fin_d       = 1'b0;
                  state_d     = ST_FLUSH;
                end
              end else begin
                err_d = 1'b1;
              end
            end
            OP_TAIL, OP_HEAD_TAIL: begin
              if (nb_bad || (op_code == OP_TAIL && state_q != ST_ABSORB)) begin
                err_d = 1'b1;
              end else begin
                if (op_code == OP_HEAD_TAIL) begin
                  buf_clr = 1'b1;
                  mode_d  = mode;
                  first_d = 1'b1;
                  done_d  = 1'b0;
                end
                buf_wr      = 1'b1;
                buf_ptr     = tail_base;
                ptr_d       = tail_end;
                blk_valid_d = 1'b1;
                blk_first_d = first_d;
                state_d     = ST_FLUSH;
                if (tail_end == tail_rate) begin
                  extra_d    = 1'b1;
                  fin_d      = 1'b0;
                  blk_last_d = 1'b0;
                end else begin
                  extra_d    = 1'b0;
                  pad_ds_en  = 1'b1;
                  pad_end_en = 1'b1;
                  fin_d      = 1'b1;
                  blk_last_d = 1'b1;
                end
              end
            end
            default: err_d = 1'b1;
          endcase
        end
      end
    endcase

    stall_d = (state_d == ST_FLUSH) || (state_d == ST_WAIT_DIG);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      mode_q      <= '0;
      first_q     <= 1'b0;
      fin_q       <= 1'b0;
      extra_q     <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      stall_q     <= 1'b0;
      blk_valid_q <= 1'b0;
      blk_first_q <= 1'b0;
      blk_last_q  <= 1'b0;
      rd_q        <= '0;
      dig_q       <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      mode_q      <= mode_d;
      first_q     <= first_d;
      fin_q       <= fin_d;
      extra_q     <= extra_d;
      done_q      <= done_d;
      err_q       <= err_d;
      stall_q     <= stall_d;
      blk_valid_q <= blk_valid_d;
      blk_first_q <= blk_first_d;
      blk_last_q  <= blk_last_d;
      rd_q        <= rd_d;
      dig_q       <= dig_d;
    end
  end

  sha3_pad_buffer #(
    .DATA_W        (DATA_W),
    .MAX_RATE_BITS (MAX_RATE_BITS)
  ) u_buf (
    .clk           (clk),
    .rst           (rst),
    .clr_i         (buf_clr),
    .wr_en_i       (buf_wr),
    .wr_ptr_i      (buf_ptr),
    .wr_data_i     (op_data),
    .wr_nbytes_i   (buf_nb),
    .pad_ds_en_i   (pad_ds_en),
    .pad_ds_pos_i  (pad_ds_pos),
    .pad_end_en_i  (pad_end_en),
    .pad_end_pos_i (pad_end_pos),
    .buf_o         (blk_data)
  );

  assign stall     = stall_q;
  assign err       = err_q;
  assign blk_valid = blk_valid_q;
  assign blk_first = blk_first_q;
  assign blk_last  = blk_last_q;
  assign rd_data   = rd_q;
  assign done      = done_q;

endmodule

// File: tb/tb_sha3_cust5_padder.sv
// Directed bench for sha3_cust5_padder: packing, padding, multi-block, backpressure, store and reset.
module tb_sha3_cust5_padder;
  import sha3_pkg::*;

  localparam int unsigned DW    = 32;
  localparam int unsigned WB    = DW / 8;
  localparam int unsigned RBITS = 1152;
  localparam int unsigned OBITS = 512;

  localparam logic [511:0] DIG_FOX = 512'h18f4f4bd419603f95538837003d9d254c26c23765565162247483f65c50303597bc9ce4d289f21d1c2f1f458828e33dc442100331b35e7eb031b5d38ba6460f8;
  localparam logic [511:0] DIG_EMPTY256 = {256'ha7ffc6f8bf1ed76651c14756a061d662f580ff4de43b49fa82d80a4b80f8434a, 256'h0};

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              op_valid = 1'b0;
  logic [3:0]        op_code = '0;
  logic [DW-1:0]     op_data = '0;
  logic [2:0]        op_nbytes = '0;
  logic [5:0]        op_sel = '0;
  logic [1:0]        mode = '0;
  logic              stall, err, blk_valid, blk_first, blk_last, done;
  logic [RBITS-1:0]  blk_data;
  logic              blk_ready = 1'b0;
  logic              dig_valid = 1'b0;
  logic [OBITS-1:0]  dig_data = '0;
  logic [DW-1:0]     rd_data;

  int                n_chk = 0;
  int                n_err = 0;
  logic [7:0]        mb [0:143];
  logic [RBITS-1:0]  exp_blk;
  string             fox = "The quick brown fox jumps over the lazy dog.";

  always #5 clk = ~clk;

  sha3_cust5_padder #(.DATA_W(DW), .MAX_RATE_BITS(RBITS), .OUT_BITS(OBITS), .SEL_W(6)) dut (
    .clk       (clk),
    .rst       (rst),
    .op_valid  (op_valid),
    .op_code   (op_code),
    .op_data   (op_data),
    .op_nbytes (op_nbytes),
    .op_sel    (op_sel),
    .mode      (mode),
    .stall     (stall),
    .err       (err),
    .blk_valid (blk_valid),
    .blk_data  (blk_data),
    .blk_first (blk_first),
    .blk_last  (blk_last),
    .blk_ready (blk_ready),
    .dig_valid (dig_valid),
    .dig_data  (dig_data),
    .rd_data   (rd_data),
    .done      (done)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One op presented for exactly one rising edge; returns on the following falling edge.
  task automatic op(input logic [3:0] code, input logic [DW-1:0] d, input int nb, input int sel);
    op_valid  = 1'b1;
    op_code   = code;
    op_data   = d;
    op_nbytes = 3'(nb);
    op_sel    = 6'(sel);
    @(negedge clk);
    op_valid  = 1'b0;
    op_code   = '0;
  endtask

  task automatic xfer();
    blk_ready = 1'b1;
    @(negedge clk);
    blk_ready = 1'b0;
  endtask

  task automatic digest(input logic [OBITS-1:0] d);
    dig_valid = 1'b1;
    dig_data  = d;
    @(negedge clk);
    dig_valid = 1'b0;
  endtask

  function automatic logic [DW-1:0] word_at(input int b);
    logic [DW-1:0] w;
    for (int k = 0; k < WB; k++) w[DW-1-8*k -: 8] = mb[b+k];
    return w;
  endfunction

  // Big-endian hex digest to core byte order (byte i at [8i+7:8i]).
  function automatic logic [OBITS-1:0] to_core(input logic [OBITS-1:0] be);
    logic [OBITS-1:0] r;
    for (int i = 0; i < OBITS/8; i++) r[8*i +: 8] = be[OBITS-1-8*i -: 8];
    return r;
  endfunction

  function automatic logic [OBITS-1:0] ramp();
    logic [OBITS-1:0] r;
    for (int i = 0; i < OBITS/8; i++) r[8*i +: 8] = 8'(i);
    return r;
  endfunction

  task automatic build_exp(input int n, input int rate, input bit pad);
    exp_blk = '0;
    for (int i = 0; i < n; i++) exp_blk[8*i +: 8] = mb[i];
    if (pad) begin
      exp_blk[8*n +: 8]        = exp_blk[8*n +: 8] ^ 8'h06;
      exp_blk[8*(rate-1) +: 8] = exp_blk[8*(rate-1) +: 8] ^ 8'h80;
    end
  endtask

  task automatic cmp_blk(input string tag);
    for (int c = 0; c < RBITS/64; c++)
      chk($sformatf("%s.q%0d", tag, c), blk_data[64*c +: 64], exp_blk[64*c +: 64]);
  endtask

  // Head + (nw-1) data words from mb, then optionally a tail with nb bytes (unused bytes 0xAA).
  task automatic send(input int nw, input int nb, input bit tail);
    logic [DW-1:0] tw;
    op(OP_HEAD, word_at(0), 0, 0);
    for (int w = 1; w < nw; w++) op(OP_DATA, word_at(WB*w), 0, 0);
    if (tail) begin
      for (int k = 0; k < WB; k++) tw[DW-1-8*k -: 8] = (k < nb) ? mb[WB*nw+k] : 8'hAA;
      op(OP_TAIL, tw, nb, 0);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_blk_valid", 64'(blk_valid), 64'h0);
    chk("rst_stall", 64'(stall), 64'h0);
    chk("rst_err", 64'(err), 64'h0);
    chk("rst_done", 64'(done), 64'h0);
    chk("rst_first_last", 64'({blk_first, blk_last}), 64'h0);
    chk("rst_rd", 64'(rd_data), 64'h0);
    chk("rst_blk_q0", blk_data[63:0], 64'h0);

    op(OP_STORE, '0, 0, 0);
    chk("store_before_digest", 64'(rd_data), 64'h0);
    op(OP_DATA, 32'h1234_5678, 0, 0);
    chk("err_data_idle", 64'(err), 64'h1);
    @(negedge clk);
    chk("err_one_cycle", 64'(err), 64'h0);
    op(4'b0011, 32'h0, 0, 0);
    chk("err_illegal", 64'(err), 64'h1);
    op(4'b0000, 32'h0, 0, 0);
    chk("err_zero_code", 64'(err), 64'h1);
    chk("illegal_no_state", 64'({stall, blk_valid}), 64'h0);

    // SHA3-512 of the fox sentence, single block
    mode = 2'd3;
    for (int i = 0; i < 44; i++) mb[i] = fox[i];
    send(11, 0, 1);
    build_exp(44, 72, 1);
    chk("fox_valid", 64'(blk_valid), 64'h1);
    chk("fox_first", 64'(blk_first), 64'h1);
    chk("fox_last", 64'(blk_last), 64'h1);
    chk("fox_stall", 64'(stall), 64'h1);
    cmp_blk("fox");
    xfer();
    chk("fox_valid_drop", 64'(blk_valid), 64'h0);
    chk("fox_wait_stall", 64'(stall), 64'h1);
    digest(to_core(DIG_FOX));
    chk("fox_done", 64'(done), 64'h1);
    chk("fox_unstall", 64'(stall), 64'h0);
    op(OP_STORE, '0, 0, 0);
    chk("fox_sel0", 64'(rd_data), 64'h18f4f4bd);
    op(OP_STORE, '0, 0, 15);
    chk("fox_sel15", 64'(rd_data), 64'hba6460f8);
    @(negedge clk);
    chk("rd_hold", 64'(rd_data), 64'hba6460f8);
    op(OP_STORE, '0, 0, 16);
    chk("sel_out_of_range", 64'(rd_data), 64'h0);
    digest(ramp());
    op(OP_STORE, '0, 0, 0);
    chk("dig_ignored_in_done", 64'(rd_data), 64'h18f4f4bd);
    op(OP_DATA, 32'h0, 0, 0);
    chk("err_data_done", 64'(err), 64'h1);

    // Multi-block: exactly 72 bytes of data, then an empty tail
    for (int i = 0; i < 72; i++) mb[i] = 8'(3*i + 1);
    send(18, 0, 0);
    build_exp(72, 72, 0);
    chk("mb1_valid", 64'(blk_valid), 64'h1);
    chk("mb1_first_last", 64'({blk_first, blk_last}), 64'h2);
    cmp_blk("mb1");
    xfer();
    digest(ramp());
    chk("mb1_back_absorb", 64'({done, stall, blk_valid}), 64'h0);
    op(OP_TAIL, 32'hAAAA_AAAA, 0, 0);
    build_exp(0, 72, 1);
    chk("mb2_valid", 64'(blk_valid), 64'h1);
    chk("mb2_first_last", 64'({blk_first, blk_last}), 64'h1);
    cmp_blk("mb2");
    xfer();
    digest(ramp());
    chk("mb2_done", 64'(done), 64'h1);
    op(OP_STORE, '0, 0, 1);
    chk("byte_order_sel1", 64'(rd_data), 64'h04050607);

    // Tail that exactly fills the block: pad-only block follows automatically
    for (int i = 0; i < 72; i++) mb[i] = 8'(i + 8'h40);
    send(17, 4, 1);
    build_exp(72, 72, 0);
    chk("fill1_first_last", 64'({blk_valid, blk_first, blk_last}), 64'h6);
    cmp_blk("fill1");
    xfer();
    digest(ramp());
    chk("fill_extra_offer", 64'({blk_valid, done}), 64'h2);
    build_exp(0, 72, 1);
    chk("fill2_first_last", 64'({blk_first, blk_last}), 64'h1);
    cmp_blk("fill2");
    xfer();
    digest(ramp());
    chk("fill_done", 64'(done), 64'h1);

    // Coincident pad byte, with backpressure held for 5 cycles
    for (int i = 0; i < 72; i++) mb[i] = 8'(8'hC0 ^ i);
    send(17, 3, 1);
    build_exp(71, 72, 1);
    chk("coin_byte71", 64'(blk_data[575:568]), 64'h86);
    chk("coin_first_last", 64'({blk_valid, blk_first, blk_last}), 64'h7);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) op(OP_DATA, 32'hDEAD_BEEF, 0, 0);
      else @(negedge clk);
      chk($sformatf("bp_valid_stall%0d", i), 64'({blk_valid, stall, err}), 64'h6);
      chk($sformatf("bp_hold_q8_%0d", i), blk_data[575:512], exp_blk[575:512]);
    end
    cmp_blk("coin");
    xfer();
    digest(ramp());

    // Empty SHA3-256 message via head+tail
    mode = 2'd1;
    for (int i = 0; i < 8; i++) mb[i] = 8'h00;
    op(OP_HEAD_TAIL, 32'hAAAA_AAAA, 0, 0);
    build_exp(0, 136, 1);
    chk("empty_first_last", 64'({blk_valid, blk_first, blk_last}), 64'h7);
    chk("empty_byte135", 64'(blk_data[1087:1080]), 64'h80);
    cmp_blk("empty");
    xfer();
    digest(to_core(DIG_EMPTY256));
    chk("empty_done", 64'(done), 64'h1);
    op(OP_STORE, '0, 0, 0);
    chk("empty_sel0", 64'(rd_data), 64'ha7ffc6f8);

    // Oversized tail byte count is rejected
    op(OP_HEAD, 32'h0102_0304, 0, 0);
    op(OP_TAIL, 32'h0, 5, 0);
    chk("err_nbytes", 64'(err), 64'h1);
    chk("nbytes_ignored", 64'({blk_valid, stall}), 64'h0);

    // Reset while a block is offered
    mode = 2'd0;
    op(OP_HEAD_TAIL, 32'h0102_0304, 2, 0);
    chk("pre_rst_valid", 64'(blk_valid), 64'h1);
    rst = 1'b1;
    #1;
    chk("rst_flush_outs", 64'({blk_valid, blk_first, blk_last, stall, err, done}), 64'h0);
    chk("rst_flush_rd", 64'(rd_data), 64'h0);
    chk("rst_flush_q0", blk_data[63:0], 64'h0);
    chk("rst_flush_q17", blk_data[1151:1088], 64'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    op(OP_STORE, '0, 0, 0);
    chk("store_after_rst", 64'(rd_data), 64'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
